// File: rtl/k052109_tmg.sv
// k052109_tmg: clock phases, H/V raster counters, raster interrupts and delayed reset for the tile-layer chip.
// Build option: define K052109_TMG_FIRQ_CMP_EN for a programmable FIRQ line compare (else FIRQ every 32 lines).
module k052109_tmg #(
   parameter int  CPU_DIV    = 8,
   parameter int  PIX_DIV    = 4,
   parameter int  HTOTAL     = 384,
   parameter int  HACT       = 320,
   parameter int  VTOTAL     = 264,
   parameter int  VBL_START  = 240,
   parameter int  RST_FRAMES = 8,
   localparam int HW         = $clog2(HTOTAL),
   localparam int VW         = $clog2(VTOTAL)
) (
   input  logic          M24,
   input  logic          RES,
   input  logic          REG_WE,
   input  logic [1:0]    REG_SEL,
   input  logic [15:0]   REG_D,
   output logic          M12,
   output logic          PE,
   output logic          PQ,
   output logic          PIXCE,
   output logic [HW-1:0] HCNT,
   output logic [VW-1:0] VCNT,
   output logic          HBLK,
   output logic          VBLK,
   output logic          HVOT,
   output logic          IRQ,
   output logic          FIRQ,
   output logic          NMI,
   output logic          RST
);
   localparam int PHW = $clog2(CPU_DIV);
   localparam int PXW = $clog2(PIX_DIV);
   localparam int RCW = $clog2(RST_FRAMES + 1);

   logic [PHW-1:0] ph_q, ph_d;
   logic           m12_q, pe_q, pq_q, pixce_q;
   logic [HW-1:0]  hcnt_q, hcnt_d;
   logic [VW-1:0]  vcnt_q, vcnt_d;
   logic           hblk_q, vblk_q, hvot_q;
   logic [2:0]     en_q, en_d, flag_q, flag_d, hit;
   logic [VW-1:0]  nmi_mask_q, nmi_mask_d;
   logic [RCW-1:0] rcnt_q, rcnt_d;
   logic           rst_q;
   logic           h_wrap, v_wrap, firq_match;
   logic           unused_d;

   assign unused_d = ^REG_D[15:VW];

   always_comb begin
      ph_d   = ph_q + 1'b1;
      h_wrap = pixce_q && (hcnt_q == HW'(HTOTAL - 1));
      v_wrap = h_wrap && (vcnt_q == VW'(VTOTAL - 1));
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (pixce_q) hcnt_d = h_wrap ? '0 : hcnt_q + 1'b1;
      if (h_wrap)  vcnt_d = v_wrap ? '0 : vcnt_q + 1'b1;
      // Raster events look at the line being entered, i.e. the next VCNT.
      hit[0] = h_wrap && (vcnt_d == VW'(VBL_START));
      hit[1] = h_wrap && firq_match;
      hit[2] = h_wrap && ((vcnt_d & nmi_mask_q) == '0);
      en_d       = (REG_WE && REG_SEL == 2'd0) ? REG_D[2:0] : en_q;
      nmi_mask_d = (REG_WE && REG_SEL == 2'd2) ? REG_D[VW-1:0] : nmi_mask_q;
      rcnt_d     = (hit[0] && rcnt_q != RCW'(RST_FRAMES)) ? rcnt_q + 1'b1 : rcnt_q;
   end

`ifdef K052109_TMG_FIRQ_CMP_EN
   logic [VW-1:0] firq_cmp_q;

   assign firq_match = (vcnt_d == firq_cmp_q);

   always_ff @(posedge M24) begin
      if (RES)                                firq_cmp_q <= '0;
      else if (REG_WE && REG_SEL == 2'd1)     firq_cmp_q <= REG_D[VW-1:0];
   end
`else
   assign firq_match = (vcnt_d[4:0] == 5'd0);
`endif

   // A flag needs both the old and any incoming enable, so a coincident disable wins.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_flag
         assign flag_d[gi] = en_q[gi] & en_d[gi] & (flag_q[gi] | hit[gi]);
      end
   endgenerate

   always_ff @(posedge M24) begin
      if (RES) begin
         ph_q       <= '0;
         m12_q      <= 1'b0;
         pe_q       <= 1'b0;
         pq_q       <= 1'b0;
         pixce_q    <= 1'b0;
         hcnt_q     <= '0;
         vcnt_q     <= '0;
         hblk_q     <= 1'b0;
         vblk_q     <= 1'b0;
         hvot_q     <= 1'b0;
         en_q       <= '0;
         flag_q     <= '0;
         nmi_mask_q <= '1;
         rcnt_q     <= '0;
         rst_q      <= 1'b0;
      end else begin
         ph_q       <= ph_d;
         m12_q      <= ph_d[0];
         pe_q       <= ph_d[PHW-1];
         pq_q       <= ph_d[PHW-1] ^ ph_d[PHW-2];
         pixce_q    <= &ph_d[PXW-1:0];
         hcnt_q     <= hcnt_d;
         vcnt_q     <= vcnt_d;
         hblk_q     <= (hcnt_d >= HW'(HACT));
         vblk_q     <= (vcnt_d >= VW'(VBL_START));
         hvot_q     <= v_wrap;
         en_q       <= en_d;
         flag_q     <= flag_d;
         nmi_mask_q <= nmi_mask_d;
         rcnt_q     <= rcnt_d;
         rst_q      <= (rcnt_d == RCW'(RST_FRAMES));
      end
   end

   assign M12   = m12_q;
   assign PE    = pe_q;
   assign PQ    = pq_q;
   assign PIXCE = pixce_q;
   assign HCNT  = hcnt_q;
   assign VCNT  = vcnt_q;
   assign HBLK  = hblk_q;
   assign VBLK  = vblk_q;
   assign HVOT  = hvot_q;
   assign IRQ   = ~flag_q[0];
   assign FIRQ  = ~flag_q[1];
   assign NMI   = ~flag_q[2];
   assign RST   = rst_q;
endmodule

// File: tb/tb_k052109_tmg.sv
// Scoreboard bench for k052109_tmg: a cycle-count reference model queues expected outputs, a monitor pops and compares.
`timescale 1ns/1ps
module tb_k052109_tmg;
   localparam int CPU_DIV = 8, PIX_DIV = 4, HTOTAL = 16, HACT = 12;
   localparam int VTOTAL = 40, VBL_START = 30, RST_FRAMES = 3;
   localparam int HW = $clog2(HTOTAL), VW = $clog2(VTOTAL);
   localparam int LINE = HTOTAL * PIX_DIV, FRAME = LINE * VTOTAL;

   logic          M24 = 1'b0, RES = 1'b1, REG_WE = 1'b0;
   logic [1:0]    REG_SEL = 2'd0;
   logic [15:0]   REG_D = 16'd0;
   logic          M12, PE, PQ, PIXCE, HBLK, VBLK, HVOT, IRQ, FIRQ, NMI, RST;
   logic [HW-1:0] HCNT;
   logic [VW-1:0] VCNT;

   always #5 M24 = ~M24;

   k052109_tmg #(
      .CPU_DIV(CPU_DIV), .PIX_DIV(PIX_DIV), .HTOTAL(HTOTAL), .HACT(HACT),
      .VTOTAL(VTOTAL), .VBL_START(VBL_START), .RST_FRAMES(RST_FRAMES)
   ) dut (
      .M24(M24), .RES(RES), .REG_WE(REG_WE), .REG_SEL(REG_SEL), .REG_D(REG_D),
      .M12(M12), .PE(PE), .PQ(PQ), .PIXCE(PIXCE), .HCNT(HCNT), .VCNT(VCNT),
      .HBLK(HBLK), .VBLK(VBLK), .HVOT(HVOT), .IRQ(IRQ), .FIRQ(FIRQ), .NMI(NMI), .RST(RST)
   );

   typedef struct packed {
      logic m12, pe, pq, pixce;
      logic [HW-1:0] h;
      logic [VW-1:0] v;
      logic hblk, vblk, hvot, irq, firq, nmi, rst;
   } snap_t;

   snap_t exp_q[$];
   int errors = 0, checks = 0;

   // Reference model: raster state is pure arithmetic on cycles since reset release.
   int t = 0, p, L, ph, hh, vv, m_cmp, m_mask, m_rcnt;
   logic ev;
   logic [2:0] m_en, m_fl, new_en, set;
   snap_t s;

   always @(posedge M24) begin : model
      if (RES) begin
         t = 0; m_en = '0; m_fl = '0; m_cmp = 0; m_mask = (1 << VW) - 1; m_rcnt = 0;
      end else begin
         t  = t + 1;
         p  = t / PIX_DIV;
         ev = ((t % PIX_DIV) == 0) && ((p % HTOTAL) == 0);
         L  = (p / HTOTAL) % VTOTAL;
         new_en = (REG_WE && REG_SEL == 2'd0) ? REG_D[2:0] : m_en;
         set[0] = ev && (L == VBL_START);
`ifdef K052109_TMG_FIRQ_CMP_EN
         set[1] = ev && (L == m_cmp);
`else
         set[1] = ev && ((L % 32) == 0);
`endif
         set[2] = ev && ((L & m_mask) == 0);
         for (int i = 0; i < 3; i++) m_fl[i] = m_en[i] && new_en[i] && (m_fl[i] || set[i]);
         if (set[0] && m_rcnt < RST_FRAMES) m_rcnt = m_rcnt + 1;
         m_en = new_en;
         if (REG_WE && REG_SEL == 2'd1) m_cmp  = int'(REG_D[VW-1:0]);
         if (REG_WE && REG_SEL == 2'd2) m_mask = int'(REG_D[VW-1:0]);
      end
      ph = t % CPU_DIV;
      p  = t / PIX_DIV;
      hh = p % HTOTAL;
      vv = (p / HTOTAL) % VTOTAL;
      s.m12   = (t % 2) == 1;
      s.pe    = ph >= CPU_DIV / 2;
      s.pq    = (ph >= CPU_DIV / 4) && (ph < 3 * CPU_DIV / 4);
      s.pixce = (t % PIX_DIV) == PIX_DIV - 1;
      s.h     = HW'(hh);
      s.v     = VW'(vv);
      s.hblk  = hh >= HACT;
      s.vblk  = vv >= VBL_START;
      s.hvot  = (t > 0) && ((t % PIX_DIV) == 0) && ((p % (HTOTAL * VTOTAL)) == 0);
      s.irq   = !m_fl[0];
      s.firq  = !m_fl[1];
      s.nmi   = !m_fl[2];
      s.rst   = m_rcnt >= RST_FRAMES;
      exp_q.push_back(s);
   end

   always @(negedge M24) begin : monitor
      snap_t e, a;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         a = {M12, PE, PQ, PIXCE, HCNT, VCNT, HBLK, VBLK, HVOT, IRQ, FIRQ, NMI, RST};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL outputs t=%0d actual m12/pe/pq/pix=%b%b%b%b h=%0d v=%0d hb/vb/hv=%b%b%b irq/firq/nmi/rst=%b%b%b%b required m12/pe/pq/pix=%b%b%b%b h=%0d v=%0d hb/vb/hv=%b%b%b irq/firq/nmi/rst=%b%b%b%b",
                     t, a.m12, a.pe, a.pq, a.pixce, a.h, a.v, a.hblk, a.vblk, a.hvot, a.irq, a.firq, a.nmi, a.rst,
                     e.m12, e.pe, e.pq, e.pixce, e.h, e.v, e.hblk, e.vblk, e.hvot, e.irq, e.firq, e.nmi, e.rst);
            if (errors >= 40) begin
               $display("Result: errors=%0d of %0d checks", errors, checks);
               $finish;
            end
         end
      end
   end

   task automatic wr(input logic [1:0] sel, input logic [15:0] d);
      REG_WE = 1'b1; REG_SEL = sel; REG_D = d;
      @(negedge M24);
      REG_WE = 1'b0;
   endtask

   task automatic rand_phase(input int n);
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(1, 150)) @(negedge M24);
         case ($urandom_range(0, 5))
            0, 1: wr(2'd0, 16'h0007);
            2:    wr(2'd0, 16'($urandom_range(0, 7)));
            3:    wr(2'd1, 16'($urandom));
            4: begin
               case ($urandom_range(0, 3))
                  0:       wr(2'd2, 16'h000F);
                  1:       wr(2'd2, 16'h0000);
                  2:       wr(2'd2, 16'h003F);
                  default: wr(2'd2, 16'($urandom));
               endcase
            end
            default: wr(2'd3, 16'($urandom));
         endcase
      end
   endtask

   initial begin : stim
      RES = 1'b1;
      repeat (3) @(negedge M24);
      RES = 1'b0;
      checks++;
      if (HCNT !== '0 || VCNT !== '0) begin
         errors++;
         $display("FAIL reset counters actual h=%0d v=%0d required h=0 v=0", HCNT, VCNT);
      end
      checks++;
      if (IRQ !== 1'b1 || FIRQ !== 1'b1 || NMI !== 1'b1) begin
         errors++;
         $display("FAIL reset irqs actual irq/firq/nmi=%b%b%b required 111", IRQ, FIRQ, NMI);
      end
      checks++;
      if (RST !== 1'b0) begin
         errors++;
         $display("FAIL reset rst actual=%b required=0", RST);
      end
      wr(2'd2, 16'h000F);
      wr(2'd1, 16'd10);
      wr(2'd0, 16'h0007);
      repeat (FRAME) @(negedge M24);
      // NMI on every line; arm it just before a line event, then disable on the event edge itself.
      wr(2'd0, 16'h0003);
      wr(2'd2, 16'h0000);
      for (int k = 0; k < LINE + 2 && (t % LINE) != LINE - 2; k++) @(negedge M24);
      wr(2'd0, 16'h0007);
      wr(2'd0, 16'h0003);
      repeat (2 * LINE) @(negedge M24);
      wr(2'd0, 16'h0007);
      rand_phase(60);
      repeat (2 * FRAME) @(negedge M24);
      repeat ($urandom_range(100, FRAME - 100)) @(negedge M24);
      RES = 1'b1;
      @(negedge M24);
      RES = 1'b0;
      checks++;
      if (HCNT !== '0 || VCNT !== '0) begin
         errors++;
         $display("FAIL midframe reset counters actual h=%0d v=%0d required h=0 v=0", HCNT, VCNT);
      end
      checks++;
      if (RST !== 1'b0) begin
         errors++;
         $display("FAIL midframe reset rst actual=%b required=0", RST);
      end
      checks++;
      if (IRQ !== 1'b1 || FIRQ !== 1'b1 || NMI !== 1'b1) begin
         errors++;
         $display("FAIL midframe reset irqs actual irq/firq/nmi=%b%b%b required 111", IRQ, FIRQ, NMI);
      end
      wr(2'd0, 16'h0007);
      repeat (FRAME) @(negedge M24);
      rand_phase(40);
      repeat (2 * FRAME) @(negedge M24);
      if (checks < 12) begin
         errors++;
         $display("FAIL check count actual=%0d required>=12", checks);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #2_000_000;
      errors++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
